// File: rtl/bufram_dp.sv
// Single-clock true dual-port buffer RAM with byte enables,
// collision forwarding and an optional zeroing sweep after reset.
`timescale 1ns/1ps
module bufram_dp #(
  parameter int    DATA_WIDTH     = 32,
  parameter int    ADDR_WIDTH     = 3,
  parameter string RDW_MODE       = "NEW_DATA",
  parameter bit    CLEAR_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_a,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [DATA_WIDTH/8-1:0] we_a,
  input  logic [DATA_WIDTH-1:0]   di_a,
  output logic [DATA_WIDTH-1:0]   do_a,
  output logic                    valid_a,
  input  logic                    en_b,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [DATA_WIDTH/8-1:0] we_b,
  input  logic [DATA_WIDTH-1:0]   di_b,
  output logic [DATA_WIDTH-1:0]   do_b,
  output logic                    valid_b,
  output logic                    busy
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  clr_we;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  acc_a, acc_b;
  logic [BYTES-1:0]      wr_a, wr_b;
  logic [DATA_WIDTH-1:0] old_a, old_b;
  logic [DATA_WIDTH-1:0] new_a, new_b;
  logic [DATA_WIDTH-1:0] rd_a, rd_b;
  logic [DATA_WIDTH-1:0] do_a_q, do_a_d;
  logic [DATA_WIDTH-1:0] do_b_q, do_b_d;
  logic                  valid_a_q, valid_a_d;
  logic                  valid_b_q, valid_b_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    unique case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(DEPTH - 1))
          state_d = READY;
      end
      READY: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy  = (state_q == CLEAR);
  assign acc_a = en_a && (state_q == READY);
  assign acc_b = en_b && (state_q == READY);
  assign wr_a  = acc_a ? we_a : '0;
  assign wr_b  = acc_b ? we_b : '0;
  assign old_a = mem_q[addr_a];
  assign old_b = mem_q[addr_b];

  // Post-write word seen by each port; port A wins shared bytes.
  always_comb begin
    new_a = old_a;
    new_b = old_b;
    for (int i = 0; i < BYTES; i++) begin
      if (wr_b[i] && addr_b == addr_a)
        new_a[8*i +: 8] = di_b[8*i +: 8];
      if (wr_a[i])
        new_a[8*i +: 8] = di_a[8*i +: 8];
      if (wr_b[i])
        new_b[8*i +: 8] = di_b[8*i +: 8];
      if (wr_a[i] && addr_a == addr_b)
        new_b[8*i +: 8] = di_a[8*i +: 8];
    end
  end

  generate
    if (RDW_MODE == "NEW_DATA") begin : g_new
      assign rd_a = new_a;
      assign rd_b = new_b;
    end else if (RDW_MODE == "OLD_DATA") begin : g_old
      assign rd_a = old_a;
      assign rd_b = old_b;
    end else begin : g_bad
      $error("bufram_dp: RDW_MODE must be NEW_DATA or OLD_DATA");
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem_q[cnt_q[ADDR_WIDTH-1:0]] <= '0;
      end else begin
        for (int i = 0; i < BYTES; i++)
          if (wr_b[i])
            mem_q[addr_b][8*i +: 8] <= di_b[8*i +: 8];
        // Later assignment takes effect, so A overrides B.
        for (int i = 0; i < BYTES; i++)
          if (wr_a[i])
            mem_q[addr_a][8*i +: 8] <= di_a[8*i +: 8];
      end
    end
  end

  always_comb begin
    do_a_d    = acc_a ? rd_a : do_a_q;
    do_b_d    = acc_b ? rd_b : do_b_q;
    valid_a_d = acc_a;
    valid_b_d = acc_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      do_a_q    <= '0;
      do_b_q    <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
    end else begin
      do_a_q    <= do_a_d;
      do_b_q    <= do_b_d;
      valid_a_q <= valid_a_d;
      valid_b_q <= valid_b_d;
    end
  end

  assign do_a    = do_a_q;
  assign do_b    = do_b_q;
  assign valid_a = valid_a_q;
  assign valid_b = valid_b_q;
endmodule

// File: tb/tb_bufram_dp.sv
// Scoreboard bench for bufram_dp: default instance against a memory model,
// plus a 64-bit OLD_DATA instance exercised with directed checks.
`timescale 1ns/1ps
module tb_bufram_dp;
  localparam int DW = 32, AW = 3, BY = 4, DEPTH = 8;
  localparam int WDW = 64, WAW = 4, WBY = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          en_a = 0, en_b = 0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [BY-1:0] we_a = '0, we_b = '0;
  logic [DW-1:0] di_a = '0, di_b = '0;
  logic [DW-1:0] do_a, do_b;
  logic          valid_a, valid_b, busy;

  bufram_dp u_dut (
    .clk(clk), .rst(rst),
    .en_a(en_a), .addr_a(addr_a), .we_a(we_a), .di_a(di_a),
    .do_a(do_a), .valid_a(valid_a),
    .en_b(en_b), .addr_b(addr_b), .we_b(we_b), .di_b(di_b),
    .do_b(do_b), .valid_b(valid_b),
    .busy(busy)
  );

  logic           w_rst = 1'b1;
  logic           w_en_a = 0, w_en_b = 0;
  logic [WAW-1:0] w_addr_a = '0, w_addr_b = '0;
  logic [WBY-1:0] w_we_a = '0, w_we_b = '0;
  logic [WDW-1:0] w_di_a = '0, w_di_b = '0;
  logic [WDW-1:0] w_do_a, w_do_b;
  logic           w_valid_a, w_valid_b, w_busy;

  bufram_dp #(
    .DATA_WIDTH(WDW), .ADDR_WIDTH(WAW),
    .RDW_MODE("OLD_DATA"), .CLEAR_ON_RESET(1'b0)
  ) u_wide (
    .clk(clk), .rst(w_rst),
    .en_a(w_en_a), .addr_a(w_addr_a), .we_a(w_we_a), .di_a(w_di_a),
    .do_a(w_do_a), .valid_a(w_valid_a),
    .en_b(w_en_b), .addr_b(w_addr_b), .we_b(w_we_b), .di_b(w_di_b),
    .do_b(w_do_b), .valid_b(w_valid_b),
    .busy(w_busy)
  );

  int n_chk = 0, n_pass = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: memory contents, pending read results, clear countdown.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] qa[$], qb[$];
  logic [DW-1:0] exp_a = '0, exp_b = '0;
  int            model_busy = 0;
  bit            mon_on = 0;

  task automatic cyc(input logic ea, input logic [AW-1:0] aa,
                     input logic [BY-1:0] wa, input logic [DW-1:0] da,
                     input logic eb, input logic [AW-1:0] ab,
                     input logic [BY-1:0] wb, input logic [DW-1:0] db);
    logic [DW-1:0] nxt [DEPTH];
    en_a = ea; addr_a = aa; we_a = wa; di_a = da;
    en_b = eb; addr_b = ab; we_b = wb; di_b = db;
    check("busy", {63'd0, busy}, {63'd0, model_busy > 0});
    if (model_busy == 0) begin
      nxt = ref_mem;
      for (int i = 0; i < BY; i++)
        if (eb && wb[i]) nxt[ab][8*i +: 8] = db[8*i +: 8];
      for (int i = 0; i < BY; i++)
        if (ea && wa[i]) nxt[aa][8*i +: 8] = da[8*i +: 8];
      if (ea) qa.push_back(nxt[aa]);
      if (eb) qb.push_back(nxt[ab]);
      ref_mem = nxt;
    end else begin
      model_busy--;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en_a = 0; en_b = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_a = '0; exp_b = '0;
    model_busy = DEPTH;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    check("rst do_a", {32'd0, do_a}, 64'd0);
    check("rst do_b", {32'd0, do_b}, 64'd0);
    check("rst valid", {62'd0, valid_a, valid_b}, 64'd0);
    check("rst busy", {63'd0, busy}, 64'd1);
  endtask

  task automatic w_cyc(input logic ea, input logic [WAW-1:0] aa,
                       input logic [WBY-1:0] wa, input logic [WDW-1:0] da,
                       input logic eb, input logic [WAW-1:0] ab,
                       input logic [WBY-1:0] wb, input logic [WDW-1:0] db);
    w_en_a = ea; w_addr_a = aa; w_we_a = wa; w_di_a = da;
    w_en_b = eb; w_addr_b = ab; w_we_b = wb; w_di_b = db;
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (valid_a) begin
          if (qa.size() == 0) check("spurious valid_a", 64'd1, 64'd0);
          else begin
            e = qa.pop_front();
            check("do_a", {32'd0, do_a}, {32'd0, e});
            exp_a = e;
          end
        end else check("hold do_a", {32'd0, do_a}, {32'd0, exp_a});
        if (valid_b) begin
          if (qb.size() == 0) check("spurious valid_b", 64'd1, 64'd0);
          else begin
            e = qb.pop_front();
            check("do_b", {32'd0, do_b}, {32'd0, e});
            exp_b = e;
          end
        end else check("hold do_b", {32'd0, do_b}, {32'd0, exp_b});
      end
    end
  end

  initial begin : driver
    logic [WDW-1:0] pat;
    logic [WDW-1:0] held;
    pat = 64'h0123456789ABCDEF;
    do_reset();
    mon_on = 1;
    for (int i = 0; i < DEPTH; i++)
      cyc(1, AW'(i), '0, '0, 0, '0, '0, '0);
    // Fill with ones, then reset and expect the sweep to zero it.
    for (int i = 0; i < DEPTH; i++)
      cyc(1, AW'(i), 4'hF, 32'hFFFFFFFF, 0, '0, '0, '0);
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      cyc(1, AW'(i), '0, '0, 1, AW'(i), '0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1, AW'(i), '0, '0, 0, '0, '0, '0);
      check("swept word", {32'd0, do_a}, 64'd0);
      check("swept valid", {63'd0, valid_a}, 64'd1);
    end
    // Reset in the middle of a sweep restarts it.
    for (int i = 0; i < DEPTH; i++)
      cyc(1, AW'(i), 4'hF, 32'h5A5A5A5A, 0, '0, '0, '0);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(0, '0, '0, '0, 0, '0, '0, '0);
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      cyc(1, '0, 4'hF, 32'h77777777, 1, '0, 4'hF, 32'h77777777);
    for (int i = 0; i < DEPTH; i++)
      cyc(0, '0, '0, '0, 1, AW'(i), '0, '0);
    // Byte-enable merge across ports.
    cyc(1, 3'd3, 4'hF, 32'h11223344, 0, '0, '0, '0);
    cyc(0, '0, '0, '0, 1, 3'd3, 4'h2, 32'hAABBCCDD);
    cyc(1, 3'd3, '0, '0, 0, '0, '0, '0);
    check("merge", {32'd0, do_a}, 64'h1122CC44);
    // Write-write collision: A wins shared byte.
    cyc(1, 3'd5, 4'h3, 32'h000000AA, 1, 3'd5, 4'h6, 32'h0000BB00);
    cyc(1, 3'd5, '0, '0, 0, '0, '0, '0);
    check("collision", {32'd0, do_a}, 64'h000000AA);
    // Read during write from the other port returns new data.
    cyc(1, 3'd2, 4'hF, 32'h12345678, 0, '0, '0, '0);
    cyc(1, 3'd2, 4'hF, 32'hDEADBEEF, 1, 3'd2, '0, '0);
    check("rdw new", {32'd0, do_b}, 64'hDEADBEEF);
    for (int k = 0; k < 400; k++) begin
      logic [AW-1:0] aa, ab;
      aa = $urandom_range(0, 1) ? AW'($urandom_range(0, 1)) : AW'($urandom);
      ab = $urandom_range(0, 1) ? AW'($urandom_range(0, 1)) : AW'($urandom);
      cyc($urandom_range(0, 3) != 0, aa,
          $urandom_range(0, 1) ? BY'($urandom) : '0, $urandom,
          $urandom_range(0, 3) != 0, ab,
          $urandom_range(0, 1) ? BY'($urandom) : '0, $urandom);
    end
    cyc(0, '0, '0, '0, 0, '0, '0, '0);
    cyc(0, '0, '0, '0, 0, '0, '0, '0);
    check("qa drained", 64'(qa.size()), 64'd0);
    check("qb drained", 64'(qb.size()), 64'd0);

    // Wide instance: no sweep, OLD_DATA read-during-write.
    w_cyc(0, '0, '0, '0, 0, '0, '0, '0);
    w_rst = 1'b0;
    check("w busy", {63'd0, w_busy}, 64'd0);
    check("w rst do_b", w_do_b, 64'd0);
    w_cyc(1, 4'd15, 8'hFF, pat, 0, '0, '0, '0);
    w_cyc(1, 4'd0, 8'hFF, pat, 0, '0, '0, '0);
    w_cyc(1, 4'd15, '0, '0, 1, 4'd0, '0, '0);
    check("w rd15", w_do_a, pat);
    check("w rd0", w_do_b, pat);
    check("w valid_b", {63'd0, w_valid_b}, 64'd1);
    held = w_do_b;
    for (int i = 0; i < 3; i++) begin
      w_cyc(1, 4'd1, 8'hFF, 64'hCAFE, 0, 4'd1, '0, '0);
      check("w hold do_b", w_do_b, held);
      check("w hold valid_b", {63'd0, w_valid_b}, 64'd0);
    end
    w_cyc(1, 4'd2, 8'hFF, 64'h12345678, 0, '0, '0, '0);
    w_cyc(1, 4'd2, 8'hFF, 64'hDEADBEEF, 1, 4'd2, '0, '0);
    check("w rdw old", w_do_b, 64'h12345678);
    w_cyc(0, '0, '0, '0, 1, 4'd2, '0, '0);
    check("w after rdw", w_do_b, 64'hDEADBEEF);
    w_cyc(0, '0, '0, '0, 0, '0, '0, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
